// File: rtl/clk_div_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_div_pkg : default divisors and effective-divisor scaling (CLK_DIV_FAST_SIM_EN)
// Revision    : 1.0
// ---------------------------------------------------------------------------
package clk_div_pkg;

  localparam int          DEF_CNT_W    = 27;
  localparam int unsigned DEF_DIV0     = 50_000_000;
  localparam int unsigned DEF_DIV1     = 5_000_000;
  localparam int unsigned DEF_DIV2     = 500_000;
  localparam int unsigned DEF_DIV3     = 50_000;
  localparam int unsigned DEF_SCAN_DIV = 100_000;
  localparam int          DEF_SCAN_W   = 2;

  function automatic int unsigned eff_div(input int unsigned value);
`ifdef CLK_DIV_FAST_SIM_EN
    return ((value / 10000) == 0) ? 1 : (value / 10000);
`else
    return value;
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_n_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mod_n_counter : counts 0..n-1 while enabled, flags the terminal count
// Revision      : 1.0
// ---------------------------------------------------------------------------
module mod_n_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] n,
  output logic         wrap
);

  logic [W-1:0] q;
  logic [W-1:0] last;

  // Strobe is decoded only from the count flop and en, so the owner can
  // register its consequences on the very edge the count wraps.
  assign last = n - W'(1);
  assign wrap = en && (q == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (wrap) begin
      q <= '0;
    end else if (en) begin
      q <= q + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_div_multi : selectable 50% divided clock plus scan selector, with ticks
// Revision      : 1.0   (CLK_DIV_FAST_SIM_EN scales all divisors down)
// ---------------------------------------------------------------------------
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          CNT_W    = DEF_CNT_W,
  parameter int unsigned DIV0     = DEF_DIV0,
  parameter int unsigned DIV1     = DEF_DIV1,
  parameter int unsigned DIV2     = DEF_DIV2,
  parameter int unsigned DIV3     = DEF_DIV3,
  parameter int unsigned SCAN_DIV = DEF_SCAN_DIV,
  parameter int          SCAN_W   = DEF_SCAN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [1:0]        sel,
  output logic              clk_out,
  output logic              tick_out,
  output logic [SCAN_W-1:0] clk_ctl,
  output logic              scan_tick
);

  localparam longint MAX_DIV = (64'sd1 <<< CNT_W) - 64'sd1;

  if (DIV0 < 1 || longint'(DIV0) > MAX_DIV) begin : g_bad_div0
    $error("clk_div_multi: DIV0 out of range");
  end
  if (DIV1 < 1 || longint'(DIV1) > MAX_DIV) begin : g_bad_div1
    $error("clk_div_multi: DIV1 out of range");
  end
  if (DIV2 < 1 || longint'(DIV2) > MAX_DIV) begin : g_bad_div2
    $error("clk_div_multi: DIV2 out of range");
  end
  if (DIV3 < 1 || longint'(DIV3) > MAX_DIV) begin : g_bad_div3
    $error("clk_div_multi: DIV3 out of range");
  end
  if (SCAN_DIV < 1 || longint'(SCAN_DIV) > MAX_DIV) begin : g_bad_scan
    $error("clk_div_multi: SCAN_DIV out of range");
  end

  localparam logic [CNT_W-1:0] D0     = CNT_W'(eff_div(DIV0));
  localparam logic [CNT_W-1:0] D1     = CNT_W'(eff_div(DIV1));
  localparam logic [CNT_W-1:0] D2     = CNT_W'(eff_div(DIV2));
  localparam logic [CNT_W-1:0] D3     = CNT_W'(eff_div(DIV3));
  localparam logic [CNT_W-1:0] SCAN_N = CNT_W'(eff_div(SCAN_DIV));

  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] div_sel;
  logic             slow_wrap;
  logic             scan_wrap;

  always_comb begin
    div_sel = D0;
    case (sel)
      2'd1:    div_sel = D1;
      2'd2:    div_sel = D2;
      2'd3:    div_sel = D3;
      default: div_sel = D0;
    endcase
  end

  mod_n_counter #(.W(CNT_W)) u_slow (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .n     (div_q),
    .wrap  (slow_wrap)
  );

  mod_n_counter #(.W(CNT_W)) u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .clr   (clr),
    .n     (SCAN_N),
    .wrap  (scan_wrap)
  );

  // The divisor only reloads at a wrap, so a half-period is never cut short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= D0;
      clk_out  <= 1'b0;
      tick_out <= 1'b0;
    end else if (clr) begin
      div_q    <= div_sel;
      clk_out  <= 1'b0;
      tick_out <= 1'b0;
    end else begin
      tick_out <= slow_wrap;
      if (slow_wrap) begin
        clk_out <= ~clk_out;
        div_q   <= div_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_ctl   <= '0;
      scan_tick <= 1'b0;
    end else if (clr) begin
      clk_ctl   <= '0;
      scan_tick <= 1'b0;
    end else begin
      scan_tick <= scan_wrap;
      if (scan_wrap) begin
        clk_ctl <= clk_ctl + SCAN_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_clk_div_multi : directed checks of both divide chains (DIV=4/2/3/1, SCAN=5)
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_clk_div_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [1:0] sel;
  logic       clk_out;
  logic       tick_out;
  logic [1:0] clk_ctl;
  logic       scan_tick;

  int vectors = 0;
  int errors  = 0;
  int scan_k  = 0;   // edges since last reset release / clr

  always #5 clk = ~clk;

  clk_div_multi #(
    .DIV0(4), .DIV1(2), .DIV2(3), .DIV3(1), .SCAN_DIV(5), .SCAN_W(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .sel       (sel),
    .clk_out   (clk_out),
    .tick_out  (tick_out),
    .clk_ctl   (clk_ctl),
    .scan_tick (scan_tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
    scan_k++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({clk_out, tick_out, clk_ctl, scan_tick} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000", {clk_out, tick_out, clk_ctl, scan_tick});
    end
    rst_n  = 1'b1;
    scan_k = 0;
  endtask

  task automatic test_div0();
    logic ec, et, es;
    logic [1:0] ectl;
    for (int j = 1; j <= 16; j++) begin
      step();
      ec = ((j / 4) % 2) == 1;
      et = (j % 4) == 0;
      ectl = 2'((scan_k / 5) % 4);
      es = (scan_k % 5) == 0;
      vectors++;
      if (clk_out !== ec || tick_out !== et) begin
        errors++;
        $display("FAIL div0 j=%0d got clk_out=%b tick=%b want %b %b", j, clk_out, tick_out, ec, et);
      end
      vectors++;
      if (clk_ctl !== ectl || scan_tick !== es) begin
        errors++;
        $display("FAIL div0_scan j=%0d got ctl=%0d stick=%b want %0d %b", j, clk_ctl, scan_tick, ectl, es);
      end
    end
  endtask

  task automatic test_sel_switch();
    logic [1:10] ec = 10'b0001100110;
    logic [1:10] et = 10'b0001010101;
    for (int j = 1; j <= 10; j++) begin
      step();
      vectors++;
      if (clk_out !== ec[j] || tick_out !== et[j]) begin
        errors++;
        $display("FAIL sel_switch j=%0d got clk_out=%b tick=%b want %b %b", j, clk_out, tick_out, ec[j], et[j]);
      end
      if (j == 2) sel = 2'd1;
    end
  endtask

  task automatic test_sel3();
    logic ec, et;
    sel = 2'd3;
    for (int j = 1; j <= 8; j++) begin
      step();
      ec = (j >= 2) && ((j % 2) == 0);
      et = (j >= 2);
      vectors++;
      if (clk_out !== ec || tick_out !== et) begin
        errors++;
        $display("FAIL sel3 j=%0d got clk_out=%b tick=%b want %b %b", j, clk_out, tick_out, ec, et);
      end
    end
  endtask

  task automatic test_en_hold();
    logic [1:13] ec = 13'b0000000000011;
    logic [1:13] et = 13'b1000000000010;
    logic es;
    logic [1:0] ectl;
    sel = 2'd0;
    for (int j = 1; j <= 13; j++) begin
      step();
      ectl = 2'((scan_k / 5) % 4);
      es = (scan_k % 5) == 0;
      vectors++;
      if (clk_out !== ec[j] || tick_out !== et[j]) begin
        errors++;
        $display("FAIL en_hold j=%0d got clk_out=%b tick=%b want %b %b", j, clk_out, tick_out, ec[j], et[j]);
      end
      vectors++;
      if (clk_ctl !== ectl || scan_tick !== es) begin
        errors++;
        $display("FAIL en_hold_scan j=%0d got ctl=%0d stick=%b want %0d %b", j, clk_ctl, scan_tick, ectl, es);
      end
      if (j == 3)  en = 1'b0;
      if (j == 10) en = 1'b1;
    end
  endtask

  task automatic test_clr();
    sel = 2'd2;
    clr = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      step();
      vectors++;
      if ({clk_out, tick_out, clk_ctl, scan_tick} !== 5'b0) begin
        errors++;
        $display("FAIL clr_held j=%0d got %b want 00000", j, {clk_out, tick_out, clk_ctl, scan_tick});
      end
    end
    clr    = 1'b0;
    scan_k = 0;
  endtask

  task automatic test_scan_run();
    logic ec, et, es;
    logic [1:0] ectl;
    int sticks = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      ec = ((j / 3) % 2) == 1;
      et = (j % 3) == 0;
      ectl = 2'((j / 5) % 4);
      es = (j % 5) == 0;
      if (scan_tick === 1'b1) sticks++;
      vectors++;
      if (clk_out !== ec || tick_out !== et) begin
        errors++;
        $display("FAIL clr_div3 j=%0d got clk_out=%b tick=%b want %b %b", j, clk_out, tick_out, ec, et);
      end
      vectors++;
      if (clk_ctl !== ectl || scan_tick !== es) begin
        errors++;
        $display("FAIL scan_run j=%0d got ctl=%0d stick=%b want %0d %b", j, clk_ctl, scan_tick, ectl, es);
      end
    end
    vectors++;
    if (sticks != 4) begin
      errors++;
      $display("FAIL scan_tick_count got %0d want 4", sticks);
    end
  endtask

  task automatic test_async_reset();
    logic ec;
    logic [1:0] ectl;
    logic [1:8] rc = 8'b00011100;
    logic [1:8] rt = 8'b00010010;
    for (int j = 21; j <= 28; j++) begin
      step();
      ec = ((j / 3) % 2) == 1;
      ectl = 2'((j / 5) % 4);
      vectors++;
      if (clk_out !== ec || clk_ctl !== ectl) begin
        errors++;
        $display("FAIL pre_reset j=%0d got clk_out=%b ctl=%0d want %b %0d", j, clk_out, clk_ctl, ec, ectl);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({clk_out, tick_out, clk_ctl, scan_tick} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset got %b want 00000", {clk_out, tick_out, clk_ctl, scan_tick});
    end
    #1;
    rst_n  = 1'b1;
    scan_k = 0;
    for (int j = 1; j <= 8; j++) begin
      step();
      vectors++;
      if (clk_out !== rc[j] || tick_out !== rt[j]) begin
        errors++;
        $display("FAIL div0_restored j=%0d got clk_out=%b tick=%b want %b %b", j, clk_out, tick_out, rc[j], rt[j]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_div0();
    test_sel_switch();
    test_sel3();
    test_en_hold();
    test_clr();
    test_scan_run();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
